// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin register-file writeback arbiter with registered write stage and pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int WIDTH = 16,
  parameter int NUMREGS = 8,
  parameter int NUMREQ = 3,
  localparam int AW = $clog2(NUMREGS),
  localparam int PW = (NUMREQ > 1) ? $clog2(NUMREQ) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [NUMREQ-1:0]                i_req,
  input  logic [NUMREQ-1:0][AW-1:0]        i_req_addr,
  input  logic [NUMREQ-1:0][WIDTH-1:0]     i_req_data,
  output logic [NUMREQ-1:0]                o_gnt,
  output logic                             o_write,
  output logic [AW-1:0]                    o_addrw,
  output logic [WIDTH-1:0]                 o_data,
  input  logic                             i_claim,
  input  logic [AW-1:0]                    i_claim_addr,
  input  logic [AW-1:0]                    i_chk_addrx,
  input  logic [AW-1:0]                    i_chk_addry,
  output logic                             o_hazard,
  output logic [NUMREGS-1:0]               o_busy,
  output logic                             o_err
);
  logic [PW-1:0] ptr, gidx, idx;
  logic found;
  logic [NUMREGS-1:0][1:0] cnt, cnt_nxt;
  logic [NUMREGS-1:0] inc, dec;
  logic err_set;
  always_comb begin
    o_gnt = '0;
    gidx = ptr;
    idx = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUMREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NUMREQ);
      if (!found && i_req[idx]) begin
        found = 1'b1;
        gidx = idx;
        o_gnt[idx] = 1'b1;
      end
    end
  end
  always_comb begin
    err_set = 1'b0;
    cnt_nxt = cnt;
    inc = '0;
    dec = '0;
    for (int r = 0; r < NUMREGS; r++) begin
      inc[r] = i_claim && (i_claim_addr == AW'(r));
      dec[r] = o_write && (o_addrw == AW'(r));
      o_busy[r] = |cnt[r];
      if (inc[r] && !dec[r]) begin
        if (cnt[r] == 2'd3) err_set = 1'b1;
        else cnt_nxt[r] = cnt[r] + 2'd1;
      end
      if (dec[r] && !inc[r]) begin
        if (cnt[r] == 2'd0) err_set = 1'b1;
        else cnt_nxt[r] = cnt[r] - 2'd1;
      end
    end
    o_hazard = o_busy[i_chk_addrx] | o_busy[i_chk_addry];
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_write <= 1'b0;
      o_addrw <= '0;
      o_data <= '0;
      o_err <= 1'b0;
      ptr <= PW'(NUMREQ - 1);
      cnt <= '0;
    end else begin
      o_write <= found;
      if (found) begin
        o_addrw <= i_req_addr[gidx];
        o_data <= i_req_data[gidx];
        ptr <= gidx;
      end
      o_err <= o_err | err_set;
      cnt <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] req = '0;
  logic [2:0][2:0] req_addr = '0;
  logic [2:0][15:0] req_data = '0;
  logic [2:0] gnt;
  logic wr;
  logic [2:0] addrw;
  logic [15:0] data;
  logic claim = 1'b0;
  logic [2:0] claim_addr = '0;
  logic [2:0] chkx = '0;
  logic [2:0] chky = '0;
  logic hazard;
  logic [7:0] busy;
  logic err;
  int checks = 0;
  int errors = 0;
  regfile_wb_arbiter dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_req_addr(req_addr), .i_req_data(req_data),
    .o_gnt(gnt), .o_write(wr), .o_addrw(addrw), .o_data(data), .i_claim(claim),
    .i_claim_addr(claim_addr), .i_chk_addrx(chkx), .i_chk_addry(chky), .o_hazard(hazard),
    .o_busy(busy), .o_err(err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; req = '0; claim = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_write got %b exp 0", wr); end
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL reset_busy got %h exp 00", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", gnt); end
  endtask
  task automatic test_single_write();
    do_reset();
    chkx = 3'd3; chky = 3'd3;
    claim = 1'b1; claim_addr = 3'd3;
    tick();
    claim = 1'b0;
    req = 3'b010; req_addr[1] = 3'd3; req_data[1] = 16'hBEEF;
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL single_gnt got %b exp 010", gnt); end
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL single_haz_n got %b exp 1", hazard); end
    tick();
    req = '0;
    #1;
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL single_write got %b exp 1", wr); end
    checks++; if (addrw !== 3'd3) begin errors++; $display("FAIL single_addr got %0d exp 3", addrw); end
    checks++; if (data !== 16'hBEEF) begin errors++; $display("FAIL single_data got %h exp beef", data); end
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL single_haz_n1 got %b exp 1", hazard); end
    tick();
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL single_write_off got %b exp 0", wr); end
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL single_busy got %h exp 00", busy); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL single_haz_clr got %b exp 0", hazard); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", err); end
  endtask
  task automatic rr_round(input string tag);
    logic [2:0] exp_g [4];
    logic [2:0] exp_a [4];
    logic [2:0] reqs [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b000};
    exp_a = '{3'd0, 3'd1, 3'd2, 3'd4};
    reqs = '{3'b111, 3'b110, 3'b100, 3'b000};
    for (int r = 0; r < 3; r++) begin
      claim = 1'b1; claim_addr = (r == 2) ? 3'd4 : 3'(r + 1);
      tick();
    end
    claim = 1'b0;
    checks++; if (busy !== 8'b0001_0110) begin errors++; $display("FAIL rr_%s_claims got %b exp 00010110", tag, busy); end
    req_addr[0] = 3'd1; req_addr[1] = 3'd2; req_addr[2] = 3'd4;
    req_data[0] = 16'h00A1; req_data[1] = 16'h00A2; req_data[2] = 16'h00A4;
    for (int c = 0; c < 4; c++) begin
      req = reqs[c];
      #1;
      checks++; if (gnt !== exp_g[c]) begin errors++; $display("FAIL rr_%s_gnt%0d got %b exp %b", tag, c, gnt, exp_g[c]); end
      if (c > 0) begin
        checks++; if (wr !== 1'b1 || addrw !== exp_a[c]) begin errors++; $display("FAIL rr_%s_wr%0d got %b/%0d exp 1/%0d", tag, c, wr, addrw, exp_a[c]); end
      end
      tick();
    end
    checks++; if (busy !== 8'h00 || err !== 1'b0) begin errors++; $display("FAIL rr_%s_drain got %h/%b exp 00/0", tag, busy, err); end
  endtask
  task automatic test_round_robin();
    do_reset();
    rr_round("a");
    rr_round("b");
  endtask
  task automatic test_rotation();
    do_reset();
    claim = 1'b1; claim_addr = 3'd0;
    tick(); tick();
    claim = 1'b0;
    req = 3'b101; req_addr[0] = 3'd0; req_addr[2] = 3'd0;
    req_data[0] = 16'h1111; req_data[2] = 16'h2222;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rot_first got %b exp 001", gnt); end
    tick();
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL rot_second got %b exp 100", gnt); end
    tick();
    req = '0;
    #1;
    checks++; if (data !== 16'h2222) begin errors++; $display("FAIL rot_data got %h exp 2222", data); end
    tick();
    checks++; if (busy !== 8'h00 || err !== 1'b0) begin errors++; $display("FAIL rot_drain got %h/%b exp 00/0", busy, err); end
  endtask
  task automatic test_simultaneous();
    do_reset();
    claim = 1'b1; claim_addr = 3'd5;
    req = 3'b001; req_addr[0] = 3'd5; req_data[0] = 16'h0555;
    tick();
    req = '0;
    #1;
    checks++; if (wr !== 1'b1 || addrw !== 3'd5) begin errors++; $display("FAIL simul_wr got %b/%0d exp 1/5", wr, addrw); end
    tick();
    claim = 1'b0;
    #1;
    checks++; if (busy !== 8'h20) begin errors++; $display("FAIL simul_busy got %h exp 20", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL simul_err got %b exp 0", err); end
  endtask
  task automatic test_overflow();
    do_reset();
    claim = 1'b1; claim_addr = 3'd6;
    tick(); tick(); tick();
    checks++; if (err !== 1'b0 || busy !== 8'h40) begin errors++; $display("FAIL ovf_pre got %b/%h exp 0/40", err, busy); end
    tick();
    claim = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", err); end
    req = 3'b001; req_addr[0] = 3'd6;
    tick(); tick(); tick();
    req = '0;
    checks++; if (busy !== 8'h40) begin errors++; $display("FAIL ovf_cnt got %h exp 40", busy); end
    tick();
    checks++; if (busy !== 8'h00 || err !== 1'b1) begin errors++; $display("FAIL ovf_drain got %h/%b exp 00/1", busy, err); end
  endtask
  task automatic test_underflow();
    do_reset();
    req = 3'b001; req_addr[0] = 3'd7;
    tick();
    req = '0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL unf_pre got %b exp 0", err); end
    tick();
    checks++; if (err !== 1'b1 || busy !== 8'h00) begin errors++; $display("FAIL unf_err got %b/%h exp 1/00", err, busy); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    claim = 1'b1; claim_addr = 3'd2;
    tick();
    claim = 1'b0;
    req = 3'b001; req_addr[0] = 3'd2; rst = 1'b1;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rmid_gnt got %b exp 001", gnt); end
    tick();
    rst = 1'b0;
    req = 3'b011;
    #1;
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL rmid_write got %b exp 0", wr); end
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL rmid_busy got %h exp 00", busy); end
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rmid_ptr got %b exp 001", gnt); end
    req = '0;
  endtask
  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_rotation();
    test_simultaneous();
    test_overflow();
    test_underflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
